// File: rtl/salu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : salu_pipe
//  Description : Scalar ALU with RV32M-style multiply/divide, valid/ready
//                handshakes on input and output, and a tag that travels with
//                each operation to writeback. Non-divide ops complete in one
//                cycle; divides use an iterative radix-2 restoring divider.
//  Revision    : 1.0 - initial release
// ============================================================================
module salu_pipe #(
   parameter int DATA_WIDTH = 32,
   parameter int TAG_WIDTH  = 5,
   parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [DATA_WIDTH-1:0] rs1_data_i,
   input  logic [DATA_WIDTH-1:0] rs2_data_i,
   input  logic [3:0]            alu_op_i,
   input  logic                  m_ext_i,
   input  logic [TAG_WIDTH-1:0]  tag_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [DATA_WIDTH-1:0] alu_res_o,
   output logic                  zero_flag_o,
   output logic                  negative_flag_o,
   output logic                  overflow_flag_o,
   output logic [TAG_WIDTH-1:0]  tag_o,
   output logic                  busy_o
);

   localparam int                     c_MSB      = DATA_WIDTH - 1;
   localparam logic [DATA_WIDTH-1:0]  c_MIN_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam logic [DATA_WIDTH-1:0]  c_ALL_ONES = {DATA_WIDTH{1'b1}};
   localparam logic [SHAMT_W-1:0]     c_CNT_LAST = SHAMT_W'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_DIV_RUN = 2'd1,
      S_DIV_FIX = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   // ------------------------------------------------------------------------
   // Handshake
   // ------------------------------------------------------------------------
   logic r_out_valid;
   logic w_out_free;
   logic w_in_ready;
   logic w_accept;
   logic w_busy;

   // The output slot is free when empty or being popped this cycle.
   assign w_out_free = !r_out_valid || out_ready_i;
   assign w_in_ready = (r_state == S_IDLE) && w_out_free;
   assign w_accept   = in_valid_i && w_in_ready;

   // ------------------------------------------------------------------------
   // Base ALU datapath
   // ------------------------------------------------------------------------
   logic                  w_a_msb;
   logic                  w_b_msb;
   logic [SHAMT_W-1:0]    w_shamt;
   logic [DATA_WIDTH-1:0] w_sum;
   logic [DATA_WIDTH-1:0] w_diff;
   logic [DATA_WIDTH-1:0] w_sra;
   logic [DATA_WIDTH-1:0] w_lt_s;
   logic [DATA_WIDTH-1:0] w_lt_u;

   assign w_a_msb = rs1_data_i[c_MSB];
   assign w_b_msb = rs2_data_i[c_MSB];
   assign w_shamt = rs2_data_i[SHAMT_W-1:0];
   assign w_sum   = rs1_data_i + rs2_data_i;
   assign w_diff  = rs1_data_i - rs2_data_i;
   assign w_sra   = $unsigned($signed(rs1_data_i) >>> w_shamt);
   assign w_lt_s  = {{(DATA_WIDTH-1){1'b0}}, ($signed(rs1_data_i) < $signed(rs2_data_i))};
   assign w_lt_u  = {{(DATA_WIDTH-1){1'b0}}, (rs1_data_i < rs2_data_i)};

   // ------------------------------------------------------------------------
   // Multiplier: operands are sign- or zero-extended to 2*DATA_WIDTH so one
   // truncated product serves MUL, MULH, MULHSU and MULHU.
   // ------------------------------------------------------------------------
   logic                      w_mul_a_sgn;
   logic                      w_mul_b_sgn;
   logic [2*DATA_WIDTH-1:0]   w_mul_a;
   logic [2*DATA_WIDTH-1:0]   w_mul_b;
   logic [2*DATA_WIDTH-1:0]   w_prod;

   assign w_mul_a_sgn = (alu_op_i[1:0] != 2'b11) && w_a_msb;
   assign w_mul_b_sgn = (alu_op_i[1:0] == 2'b01) && w_b_msb;
   assign w_mul_a     = {{DATA_WIDTH{w_mul_a_sgn}}, rs1_data_i};
   assign w_mul_b     = {{DATA_WIDTH{w_mul_b_sgn}}, rs2_data_i};
   assign w_prod      = w_mul_a * w_mul_b;

   // ------------------------------------------------------------------------
   // Divide decode and single-cycle corner cases
   // ------------------------------------------------------------------------
   logic                  w_is_div;
   logic                  w_div_signed;
   logic                  w_div_rem;
   logic                  w_div_by0;
   logic                  w_div_ovf;
   logic                  w_div_fast;
   logic                  w_start_div;
   logic [DATA_WIDTH-1:0] w_fast_res;
   logic                  w_a_neg;
   logic                  w_b_neg;
   logic [DATA_WIDTH-1:0] w_abs_a;
   logic [DATA_WIDTH-1:0] w_abs_b;

   assign w_is_div     = m_ext_i && alu_op_i[2];
   assign w_div_signed = !alu_op_i[0];
   assign w_div_rem    = alu_op_i[1];
   assign w_div_by0    = (rs2_data_i == '0);
   assign w_div_ovf    = w_is_div && w_div_signed &&
                         (rs1_data_i == c_MIN_NEG) && (rs2_data_i == c_ALL_ONES);
   assign w_div_fast   = w_div_by0 || w_div_ovf;
   assign w_start_div  = w_accept && w_is_div && !w_div_fast;

   assign w_fast_res = w_div_by0 ? (w_div_rem ? rs1_data_i : c_ALL_ONES)
                                 : (w_div_rem ? '0 : c_MIN_NEG);

   assign w_a_neg = w_div_signed && w_a_msb;
   assign w_b_neg = w_div_signed && w_b_msb;
   assign w_abs_a = w_a_neg ? (~rs1_data_i + 1'b1) : rs1_data_i;
   assign w_abs_b = w_b_neg ? (~rs2_data_i + 1'b1) : rs2_data_i;

   // ------------------------------------------------------------------------
   // Single-cycle result selection
   // ------------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] w_imm_res;
   logic                  w_imm_ovf;

   // Result and overflow for every op that completes in the accepting cycle.
   always_comb begin
      w_imm_res = '0;
      w_imm_ovf = 1'b0;
      if (m_ext_i) begin
         case (alu_op_i[2:0])
            3'd0:             w_imm_res = w_prod[DATA_WIDTH-1:0];
            3'd1, 3'd2, 3'd3: w_imm_res = w_prod[2*DATA_WIDTH-1:DATA_WIDTH];
            default: begin
               w_imm_res = w_fast_res;
               w_imm_ovf = w_div_ovf;
            end
         endcase
      end else begin
         case (alu_op_i)
            4'h0: begin
               w_imm_res = w_sum;
               w_imm_ovf = (w_a_msb == w_b_msb) && (w_sum[c_MSB] != w_a_msb);
            end
            4'h1: begin
               w_imm_res = w_diff;
               w_imm_ovf = (w_a_msb != w_b_msb) && (w_diff[c_MSB] != w_a_msb);
            end
            4'h2:             w_imm_res = rs1_data_i << w_shamt;
            4'h3, 4'hC, 4'hD: w_imm_res = w_lt_s;
            4'h4, 4'hE, 4'hF: w_imm_res = w_lt_u;
            4'h5:             w_imm_res = rs1_data_i ^ rs2_data_i;
            4'h6:             w_imm_res = rs1_data_i >> w_shamt;
            4'h7:             w_imm_res = w_sra;
            4'h8:             w_imm_res = rs1_data_i | rs2_data_i;
            4'h9:             w_imm_res = rs1_data_i & rs2_data_i;
            4'hA, 4'hB:       w_imm_res = w_diff;
            default:          w_imm_res = '0;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Iterative restoring divider. r_dvd starts as |dividend| and fills with
   // quotient bits from the right as dividend bits shift out on the left.
   // ------------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] r_dvd;
   logic [DATA_WIDTH-1:0] r_dvs;
   logic [DATA_WIDTH-1:0] r_rem;
   logic [SHAMT_W-1:0]    r_cnt;
   logic                  r_neg_q;
   logic                  r_neg_r;
   logic                  r_is_rem;
   logic [TAG_WIDTH-1:0]  r_div_tag;

   logic [DATA_WIDTH:0]   w_shift;
   logic [DATA_WIDTH:0]   w_trial;
   logic                  w_fits;
   logic [DATA_WIDTH-1:0] w_q_fix;
   logic [DATA_WIDTH-1:0] w_r_fix;
   logic [DATA_WIDTH-1:0] w_fix_res;

   assign w_shift   = {r_rem, r_dvd[c_MSB]};
   assign w_trial   = w_shift - {1'b0, r_dvs};
   assign w_fits    = !w_trial[DATA_WIDTH];
   assign w_q_fix   = r_neg_q ? (~r_dvd + 1'b1) : r_dvd;
   assign w_r_fix   = r_neg_r ? (~r_rem + 1'b1) : r_rem;
   assign w_fix_res = r_is_rem ? w_r_fix : w_q_fix;

   // Divider operand capture on acceptance, then one restoring step per cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_dvd     <= '0;
         r_dvs     <= '0;
         r_rem     <= '0;
         r_cnt     <= '0;
         r_neg_q   <= 1'b0;
         r_neg_r   <= 1'b0;
         r_is_rem  <= 1'b0;
         r_div_tag <= '0;
      end else if (w_start_div) begin
         r_dvd     <= w_abs_a;
         r_dvs     <= w_abs_b;
         r_rem     <= '0;
         r_cnt     <= '0;
         r_neg_q   <= w_a_neg ^ w_b_neg;
         r_neg_r   <= w_a_neg;
         r_is_rem  <= w_div_rem;
         r_div_tag <= tag_i;
      end else if (r_state == S_DIV_RUN) begin
         r_dvd <= {r_dvd[DATA_WIDTH-2:0], w_fits};
         r_rem <= w_fits ? w_trial[DATA_WIDTH-1:0] : w_shift[DATA_WIDTH-1:0];
         r_cnt <= r_cnt + SHAMT_W'(1);
      end
   end

   // ------------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------------
   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and busy indication.
   always_comb begin
      w_state_nxt = r_state;
      w_busy      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_start_div) begin
               w_state_nxt = S_DIV_RUN;
            end
         end
         S_DIV_RUN: begin
            w_busy = 1'b1;
            if (r_cnt == c_CNT_LAST) begin
               w_state_nxt = S_DIV_FIX;
            end
         end
         S_DIV_FIX: begin
            w_busy = 1'b1;
            if (w_out_free) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Output register
   // ------------------------------------------------------------------------
   logic                  w_load_imm;
   logic                  w_load_fix;
   logic                  w_load;
   logic [DATA_WIDTH-1:0] w_load_res;
   logic                  w_load_ovf;
   logic [TAG_WIDTH-1:0]  w_load_tag;

   assign w_load_imm = w_accept && !w_start_div;
   assign w_load_fix = (r_state == S_DIV_FIX) && w_out_free;
   assign w_load     = w_load_imm || w_load_fix;
   assign w_load_res = w_load_fix ? w_fix_res : w_imm_res;
   assign w_load_ovf = w_load_fix ? 1'b0 : w_imm_ovf;
   assign w_load_tag = w_load_fix ? r_div_tag : tag_i;

   logic [DATA_WIDTH-1:0] r_res;
   logic                  r_zero;
   logic                  r_neg;
   logic                  r_ovf;
   logic [TAG_WIDTH-1:0]  r_tag;

   // Load a new result (replacing any popped one) or drop valid on a bare pop.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_res       <= '0;
         r_zero      <= 1'b0;
         r_neg       <= 1'b0;
         r_ovf       <= 1'b0;
         r_tag       <= '0;
      end else if (w_load) begin
         r_out_valid <= 1'b1;
         r_res       <= w_load_res;
         r_zero      <= (w_load_res == '0);
         r_neg       <= w_load_res[c_MSB];
         r_ovf       <= w_load_ovf;
         r_tag       <= w_load_tag;
      end else if (out_ready_i) begin
         r_out_valid <= 1'b0;
      end
   end

   assign in_ready_o      = w_in_ready;
   assign busy_o          = w_busy;
   assign out_valid_o     = r_out_valid;
   assign alu_res_o       = r_res;
   assign zero_flag_o     = r_zero;
   assign negative_flag_o = r_neg;
   assign overflow_flag_o = r_ovf;
   assign tag_o           = r_tag;

endmodule
`default_nettype wire

// File: tb/tb_salu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_salu_pipe
//  Description : Self-checking bench for salu_pipe: directed cases plus
//                randomized traffic scored against an arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_salu_pipe;

   localparam int DW = 32;
   localparam int TW = 5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid_i;
   logic          in_ready_o;
   logic [DW-1:0] rs1_data_i;
   logic [DW-1:0] rs2_data_i;
   logic [3:0]    alu_op_i;
   logic          m_ext_i;
   logic [TW-1:0] tag_i;
   logic          out_valid_o;
   logic          out_ready_i;
   logic [DW-1:0] alu_res_o;
   logic          zero_flag_o;
   logic          negative_flag_o;
   logic          overflow_flag_o;
   logic [TW-1:0] tag_o;
   logic          busy_o;

   salu_pipe #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .in_valid_i      (in_valid_i),
      .in_ready_o      (in_ready_o),
      .rs1_data_i      (rs1_data_i),
      .rs2_data_i      (rs2_data_i),
      .alu_op_i        (alu_op_i),
      .m_ext_i         (m_ext_i),
      .tag_i           (tag_i),
      .out_valid_o     (out_valid_o),
      .out_ready_i     (out_ready_i),
      .alu_res_o       (alu_res_o),
      .zero_flag_o     (zero_flag_o),
      .negative_flag_o (negative_flag_o),
      .overflow_flag_o (overflow_flag_o),
      .tag_o           (tag_o),
      .busy_o          (busy_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] res;
      logic          ovf;
      logic [TW-1:0] tag;
      int            acc;
      int            lat;
      bit            seen;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   bit   accepted;
   bit   last_in_ready;
   bit   lat_chk;
   bit   div_watch;

   task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Reference behaviour from plain 64-bit arithmetic.
   function automatic void ref_model(input logic m, input logic [3:0] op,
                                     input logic [DW-1:0] a, input logic [DW-1:0] b,
                                     output logic [DW-1:0] r, output logic ov);
      longint sa, sb, ua, ub, p;
      bit     sovf;
      sa   = longint'($signed(a));
      sb   = longint'($signed(b));
      ua   = longint'({32'h0, a});
      ub   = longint'({32'h0, b});
      sovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      r    = '0;
      ov   = 1'b0;
      p    = 0;
      if (m) begin
         case (op[2:0])
            3'd0: begin p = sa * sb; r = p[31:0];  end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: begin
               if (b == 0)    r = 32'hFFFF_FFFF;
               else if (sovf) begin r = 32'h8000_0000; ov = 1'b1; end
               else begin p = sa / sb; r = p[31:0]; end
            end
            3'd5: begin
               if (b == 0) r = 32'hFFFF_FFFF;
               else begin p = ua / ub; r = p[31:0]; end
            end
            3'd6: begin
               if (b == 0)    r = a;
               else if (sovf) begin r = 32'h0; ov = 1'b1; end
               else begin p = sa % sb; r = p[31:0]; end
            end
            default: begin
               if (b == 0) r = a;
               else begin p = ua % ub; r = p[31:0]; end
            end
         endcase
      end else begin
         case (op)
            4'h0: begin
               p  = sa + sb; r = p[31:0];
               ov = (p > 64'sd2147483647) || (p < -(64'sd2147483648));
            end
            4'h1: begin
               p  = sa - sb; r = p[31:0];
               ov = (p > 64'sd2147483647) || (p < -(64'sd2147483648));
            end
            4'h2:             r = a << b[4:0];
            4'h3, 4'hC, 4'hD: r = (sa < sb) ? 32'd1 : 32'd0;
            4'h4, 4'hE, 4'hF: r = (ua < ub) ? 32'd1 : 32'd0;
            4'h5:             r = a ^ b;
            4'h6:             r = a >> b[4:0];
            4'h7: begin p = sa >>> b[4:0]; r = p[31:0]; end
            4'h8:             r = a | b;
            4'h9:             r = a & b;
            default:          r = a - b;
         endcase
      end
   endfunction

   function automatic int exp_latency(input logic m, input logic [3:0] op,
                                      input logic [DW-1:0] a, input logic [DW-1:0] b);
      bit iterative;
      iterative = m && op[2] && (b != 0) &&
                  !(!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
      return iterative ? DW + 2 : 1;
   endfunction

   // One clock: sample DUT away from the edge, score, record acceptance.
   task automatic step();
      exp_t e;
      logic [DW-1:0] r;
      logic ov;
      #2;
      last_in_ready = in_ready_o;
      if (out_valid_o === 1'b1) begin
         if (q.size() == 0) begin
            check_eq("spurious_valid", out_valid_o, 1'b0);
         end else begin
            e = q[0];
            check_eq("res", alu_res_o, e.res);
            check_eq("zero", zero_flag_o, (e.res == 0));
            check_eq("neg", negative_flag_o, e.res[DW-1]);
            check_eq("ovf", overflow_flag_o, e.ovf);
            check_eq("tag", tag_o, e.tag);
            if (!e.seen && e.lat != 0) check_eq("latency", cyc - e.acc, e.lat);
            q[0].seen = 1'b1;
            if (out_ready_i) void'(q.pop_front());
         end
      end else if (q.size() != 0 && (cyc - q[0].acc) > 2 * DW) begin
         check_eq("result_timeout", out_valid_o, 1'b1);
         q.delete();
      end
      if (div_watch && out_valid_o !== 1'b1) begin
         check_eq("div_busy", busy_o, 1'b1);
         check_eq("div_in_ready", in_ready_o, 1'b0);
      end
      accepted = rst_n && in_valid_i && (in_ready_o === 1'b1);
      if (accepted) begin
         ref_model(m_ext_i, alu_op_i, rs1_data_i, rs2_data_i, r, ov);
         e.res  = r;
         e.ovf  = ov;
         e.tag  = tag_i;
         e.acc  = cyc;
         e.lat  = lat_chk ? exp_latency(m_ext_i, alu_op_i, rs1_data_i, rs2_data_i) : 0;
         e.seen = 1'b0;
         q.push_back(e);
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic send(input logic m, input logic [3:0] op, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [TW-1:0] t);
      int n;
      n          = 0;
      in_valid_i = 1'b1;
      m_ext_i    = m;
      alu_op_i   = op;
      rs1_data_i = a;
      rs2_data_i = b;
      tag_i      = t;
      do begin
         step();
         n++;
      end while (!accepted && n < 200);
      if (!accepted) check_eq("accept_timeout", accepted, 1'b1);
      in_valid_i = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      in_valid_i  = 1'b0;
      out_ready_i = 1'b1;
      while (q.size() != 0 && n < 200) begin
         step();
         n++;
      end
   endtask

   function automatic logic [DW-1:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return 32'h0;
         1:       return 32'h1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      rst_n       = 1'b0;
      in_valid_i  = 1'b0;
      out_ready_i = 1'b1;
      rs1_data_i  = '0;
      rs2_data_i  = '0;
      alu_op_i    = '0;
      m_ext_i     = 1'b0;
      tag_i       = '0;
      lat_chk     = 1'b1;
      div_watch   = 1'b0;

      // Reset state
      step();
      step();
      check_eq("rst_valid", out_valid_o, 1'b0);
      check_eq("rst_busy", busy_o, 1'b0);
      check_eq("rst_res", alu_res_o, '0);
      check_eq("rst_tag", tag_o, '0);
      check_eq("rst_flags", {zero_flag_o, negative_flag_o, overflow_flag_o}, 3'b000);
      rst_n = 1'b1;

      // ADD overflow
      send(1'b0, 4'h0, 32'h7FFF_FFFF, 32'h1, 5'd3);
      drain();

      // Back-to-back single-cycle ops at full throughput
      send(1'b0, 4'h7, 32'h8000_0000, 32'h24, 5'd4);
      send(1'b0, 4'h4, 32'h1, 32'hFFFF_FFFF, 5'd5);
      send(1'b0, 4'h3, 32'h1, 32'hFFFF_FFFF, 5'd6);
      send(1'b1, 4'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
      send(1'b1, 4'h3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8);
      send(1'b1, 4'h8, 32'd7, 32'hFFFF_FFFD, 5'd9);
      send(1'b0, 4'hB, 32'd5, 32'd5, 5'd10);
      drain();

      // Output stall: held result must stay stable, no new accept
      lat_chk     = 1'b0;
      out_ready_i = 1'b0;
      send(1'b0, 4'h9, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd11);
      in_valid_i  = 1'b1;
      m_ext_i     = 1'b0;
      alu_op_i    = 4'h5;
      rs1_data_i  = 32'h1234_5678;
      rs2_data_i  = 32'h1234_5678;
      tag_i       = 5'd12;
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq("hold_in_ready", last_in_ready, 1'b0);
      end
      out_ready_i = 1'b1;
      send(1'b0, 4'h5, 32'h1234_5678, 32'h1234_5678, 5'd12);
      send(1'b0, 4'h6, 32'h8000_0000, 32'd31, 5'd13);
      drain();

      // Divides
      lat_chk = 1'b1;
      send(1'b1, 4'h4, 32'hFFFF_FFF9, 32'd2, 5'd14);
      div_watch = 1'b1;
      drain();
      div_watch = 1'b0;
      send(1'b1, 4'h6, 32'hFFFF_FFF9, 32'd2, 5'd15);
      div_watch = 1'b1;
      drain();
      div_watch = 1'b0;
      send(1'b1, 4'h5, 32'd5, 32'd0, 5'd16);
      drain();
      send(1'b1, 4'h4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17);
      drain();
      send(1'b1, 4'h7, 32'hDEAD_BEEF, 32'd1000, 5'd18);
      drain();

      // Reset in the middle of a divide aborts it
      send(1'b1, 4'h5, 32'd1000, 32'd7, 5'd19);
      for (int i = 0; i < 10; i++) step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      q.delete();
      #1;
      check_eq("abort_valid", out_valid_o, 1'b0);
      check_eq("abort_busy", busy_o, 1'b0);
      check_eq("abort_in_ready", in_ready_o, 1'b1);
      send(1'b0, 4'h0, 32'd2, 32'd2, 5'd20);
      drain();

      // Randomized traffic with random back-pressure
      lat_chk = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         out_ready_i = ($urandom_range(0, 9) < 7);
         in_valid_i  = ($urandom_range(0, 9) < 6);
         m_ext_i     = ($urandom_range(0, 3) == 0);
         alu_op_i    = 4'($urandom_range(0, 15));
         rs1_data_i  = pick_operand();
         rs2_data_i  = pick_operand();
         tag_i       = 5'($urandom_range(0, 31));
         step();
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
